vga_rect_filler: RTL and testbench
==================================

VGA_RECT_FILLER -- requirements
Module: vga_rect_filler

Interface
REQ-001 Parameter: SCREEN_W, default 160, drawable width in pixels.
REQ-002 Parameter: SCREEN_H, default 120, drawable height in pixels.
REQ-003 CLOCK_50  input  1  system clock; all state changes on its rising edge.
REQ-004 resetn  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request a fill; sampled only in IDLE.
REQ-006 clear  input  1  sampled with start; 1 = fill the whole screen and ignore x_in/y_in/w_in/h_in.
REQ-007 x_in  input  8  rectangle left column.
REQ-008 y_in  input  7  rectangle top row.
REQ-009 w_in  input  8  rectangle width in pixels.
REQ-010 h_in  input  7  rectangle height in pixels.
REQ-011 colour_in  input  3  fill colour (R,G,B bits).
REQ-012 x  output  8  pixel column to the downstream VGA adapter.
REQ-013 y  output  7  pixel row to the downstream VGA adapter.
REQ-014 colour  output  3  pixel colour to the downstream VGA adapter.
REQ-015 plot  output  1  pixel write strobe; x/y/colour are valid when plot=1.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 done  output  1  one-cycle completion pulse.

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, DRAW and DONE.
REQ-019 All outputs SHALL be registered.
REQ-020 In IDLE, start=1 SHALL latch colour_in and the clipped origin and extents, then transition to DRAW, or to DONE if either clipped extent is 0.
REQ-021 Clipping: eff_w = 0 if x_in >= SCREEN_W, else min(w_in, SCREEN_W - x_in); eff_h = 0 if y_in >= SCREEN_H, else min(h_in, SCREEN_H - y_in).
REQ-022 Clipping arithmetic SHALL be unsigned, and no pixel outside 0..SCREEN_W-1 / 0..SCREEN_H-1 SHALL ever be emitted.
REQ-023 clear=1 SHALL force origin (0,0) and extents SCREEN_W x SCREEN_H.
REQ-024 DRAW SHALL emit exactly one pixel per cycle with plot=1, in row-major order (x increments fastest), producing eff_w*eff_h pixels with no gaps.
REQ-025 The first pixel SHALL appear with plot=1 in the cycle immediately after the cycle in which start was sampled.
REQ-026 When the pixel with x = origin_x+eff_w-1 is emitted, the next pixel SHALL wrap x to origin_x and advance y by 1.
REQ-027 After the pixel at (origin_x+eff_w-1, origin_y+eff_h-1) is emitted, the FSM SHALL go to DONE.
REQ-028 DONE SHALL last exactly one cycle with done=1 and plot=0, then return to IDLE.
REQ-029 An empty rectangle SHALL produce done=1 in the cycle after start with no plot pulses.
REQ-030 start asserted in DRAW or DONE SHALL be ignored and SHALL NOT be queued; inputs SHALL NOT be sampled outside IDLE.
REQ-031 plot SHALL be 0 in IDLE and DONE; x/y/colour SHALL hold their last values when plot=0.
REQ-032 For N pixels, busy SHALL be high for N+1 cycles (DRAW plus DONE).

Reset
REQ-033 resetn=0 SHALL immediately, without waiting for a clock edge, force state IDLE, x=0, y=0, colour=0, plot=0, busy=0 and done=0.
REQ-034 Reset asserted mid-DRAW SHALL abort the fill, produce no done pulse, and emit no further pixels after release.
REQ-035 After resetn is released, the first start SHALL be accepted on the first rising edge.

Verification
REQ-036 Reset check: assert resetn=0 between clock edges -> all outputs read 0 before the next edge.
REQ-037 Basic fill: x_in=10, y_in=20, w_in=3, h_in=2, colour_in=5 -> plot=1 on cycles 1..6 with (10,20) (11,20) (12,20) (10,21) (11,21) (12,21), colour=5; done=1 on cycle 7 only; busy high on cycles 1..7.
REQ-038 Clipped fill: x_in=158, y_in=119, w_in=5, h_in=4 -> exactly two pixels, (158,119) then (159,119), followed by done; out-of-range origin x_in=200 -> no plots, done=1 on cycle 1.
REQ-039 Clear screen: clear=1, colour_in=0 -> 19200 consecutive plots, first (0,0), 160th (159,0), 161st (0,1), last (159,119); done=1 on cycle 19201.
REQ-040 Zero extent: w_in=0 or h_in=0 -> plot never asserted, done=1 on cycle 1, IDLE on cycle 2.
REQ-041 Ignored start and abort: start pulsed during DRAW -> pixel sequence and pixel count unchanged; resetn pulsed low at pixel 3 of a 3x2 fill -> outputs forced to 0, no done pulse, no further plots.

Source files
------------

// File: rtl/vga_rect_filler.sv
// Rectangle filler for a VGA pixel adapter: clips a rectangle to the screen
// and streams its pixels one per cycle in row-major order.
module vga_rect_filler #(
   parameter int SCREEN_W = 160,
   parameter int SCREEN_H = 120
) (
   input  logic       CLOCK_50,
   input  logic       resetn,
   input  logic       start,
   input  logic       clear,
   input  logic [7:0] x_in,
   input  logic [6:0] y_in,
   input  logic [7:0] w_in,
   input  logic [6:0] h_in,
   input  logic [2:0] colour_in,
   output logic [7:0] x,
   output logic [6:0] y,
   output logic [2:0] colour,
   output logic       plot,
   output logic       busy,
   output logic       done
);

   localparam logic [8:0] SW = 9'(SCREEN_W);
   localparam logic [7:0] SH = 8'(SCREEN_H);

   typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

   state_t     state_q, state_d;
   logic [7:0] x_q, x_d, ox_q, ox_d, lx_q, lx_d;
   logic [6:0] y_q, y_d, ly_q, ly_d;
   logic [2:0] colour_q, colour_d;
   logic       plot_q, plot_d, busy_q, busy_d, done_q, done_d;

   logic [7:0] org_x;
   logic [6:0] org_y;
   logic [8:0] eff_w, rem_w;
   logic [7:0] eff_h, rem_h;
   logic [7:0] last_x;
   logic [6:0] last_y;

   // Clipping is done in one extra bit so SCREEN - origin never wraps.
   always_comb begin
      rem_w = SW - {1'b0, x_in};
      rem_h = SH - {1'b0, y_in};
      if (clear) begin
         org_x = '0;
         org_y = '0;
         eff_w = SW;
         eff_h = SH;
      end else begin
         org_x = x_in;
         org_y = y_in;
         if ({1'b0, x_in} >= SW)         eff_w = '0;
         else if ({1'b0, w_in} < rem_w)  eff_w = {1'b0, w_in};
         else                            eff_w = rem_w;
         if ({1'b0, y_in} >= SH)         eff_h = '0;
         else if ({1'b0, h_in} < rem_h)  eff_h = {1'b0, h_in};
         else                            eff_h = rem_h;
      end
      last_x = 8'(({1'b0, org_x} + eff_w) - 9'd1);
      last_y = 7'(({1'b0, org_y} + eff_h) - 8'd1);
   end

   always_comb begin
      state_d  = state_q;
      x_d      = x_q;
      y_d      = y_q;
      colour_d = colour_q;
      ox_d     = ox_q;
      lx_d     = lx_q;
      ly_d     = ly_q;
      plot_d   = 1'b0;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               busy_d = 1'b1;
               ox_d   = org_x;
               lx_d   = last_x;
               ly_d   = last_y;
               if (eff_w == '0 || eff_h == '0) begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end else begin
                  // First pixel goes out together with the DRAW entry.
                  state_d  = DRAW;
                  x_d      = org_x;
                  y_d      = org_y;
                  colour_d = colour_in;
                  plot_d   = 1'b1;
               end
            end
         end
         DRAW: begin
            busy_d = 1'b1;
            if (x_q == lx_q) begin
               if (y_q == ly_q) begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end else begin
                  x_d    = ox_q;
                  y_d    = y_q + 7'd1;
                  plot_d = 1'b1;
               end
            end else begin
               x_d    = x_q + 8'd1;
               plot_d = 1'b1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         state_q  <= IDLE;
         x_q      <= '0;
         y_q      <= '0;
         colour_q <= '0;
         ox_q     <= '0;
         lx_q     <= '0;
         ly_q     <= '0;
         plot_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         x_q      <= x_d;
         y_q      <= y_d;
         colour_q <= colour_d;
         ox_q     <= ox_d;
         lx_q     <= lx_d;
         ly_q     <= ly_d;
         plot_q   <= plot_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign x      = x_q;
   assign y      = y_q;
   assign colour = colour_q;
   assign plot   = plot_q;
   assign busy   = busy_q;
   assign done   = done_q;

endmodule

// File: tb/tb_vga_rect_filler.sv
// Directed bench for vga_rect_filler: table of fills with hand-computed
// clipped extents, plus reset, abort and ignored-start sequences.
module tb_vga_rect_filler;

   logic       CLOCK_50 = 1'b0;
   logic       resetn = 1'b0;
   logic       start = 1'b0;
   logic       clear = 1'b0;
   logic [7:0] x_in = '0;
   logic [6:0] y_in = '0;
   logic [7:0] w_in = '0;
   logic [6:0] h_in = '0;
   logic [2:0] colour_in = '0;
   logic [7:0] x;
   logic [6:0] y;
   logic [2:0] colour;
   logic       plot, busy, done;

   vga_rect_filler #(.SCREEN_W(160), .SCREEN_H(120)) dut (
      .CLOCK_50(CLOCK_50), .resetn(resetn), .start(start), .clear(clear),
      .x_in(x_in), .y_in(y_in), .w_in(w_in), .h_in(h_in), .colour_in(colour_in),
      .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy), .done(done)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   int tests = 0;
   int fails = 0;

   typedef struct {
      bit clr;
      int xi, yi, wi, hi, col;
      int ox, oy, ew, eh;
   } vec_t;

   vec_t vecs[9];

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Drives one fill and compares every cycle against the expected stream.
   task automatic run_vec(input vec_t v, input bit poke, input string tag);
      int n, errs, done_c, first_done, busy_c, ex, ey;
      n = v.ew * v.eh;
      errs = 0; done_c = 0; first_done = -1; busy_c = 0;
      @(negedge CLOCK_50);
      clear = v.clr; x_in = 8'(v.xi); y_in = 7'(v.yi);
      w_in = 8'(v.wi); h_in = 7'(v.hi); colour_in = 3'(v.col);
      start = 1'b1;
      @(posedge CLOCK_50); #1;
      start = 1'b0;
      clear = 1'b0; x_in = 8'd1; y_in = 7'd1; w_in = 8'd1; h_in = 7'd1; colour_in = 3'd1;
      for (int c = 1; c <= n + 3; c++) begin
         if (poke && (c == 2 || c == n + 1)) start = 1'b1;
         if (poke && (c == 3 || c == n + 2)) start = 1'b0;
         if (c <= n) begin
            ex = v.ox + (c - 1) % v.ew;
            ey = v.oy + (c - 1) / v.ew;
            if (plot !== 1'b1 || x !== 8'(ex) || y !== 7'(ey) || colour !== 3'(v.col)) begin
               if (errs == 0)
                  $display("FAIL %s pixel %0d: got plot=%0b (%0d,%0d) col=%0d expected (%0d,%0d) col=%0d",
                           tag, c, plot, x, y, colour, ex, ey, v.col);
               errs++;
            end
         end else begin
            if (plot !== 1'b0 ||
                (n > 0 && (x !== 8'(v.ox + v.ew - 1) || y !== 7'(v.oy + v.eh - 1) ||
                           colour !== 3'(v.col)))) begin
               if (errs == 0)
                  $display("FAIL %s idle cycle %0d: got plot=%0b (%0d,%0d) col=%0d",
                           tag, c, plot, x, y, colour);
               errs++;
            end
         end
         if (done === 1'b1) begin
            done_c++;
            if (first_done < 0) first_done = c;
         end
         if (busy === 1'b1) busy_c++;
         @(posedge CLOCK_50); #1;
      end
      check({tag, "_pixel_errors"}, errs, 0);
      check({tag, "_done_cycle"}, first_done, n + 1);
      check({tag, "_done_count"}, done_c, 1);
      check({tag, "_busy_cycles"}, busy_c, n + 1);
   endtask

   initial begin
      int pc, dc;
      vecs[0] = '{0, 10, 20, 3, 2, 5,     10, 20, 3, 2};
      vecs[1] = '{0, 158, 119, 5, 4, 3,   158, 119, 2, 1};
      vecs[2] = '{0, 200, 5, 4, 4, 1,     200, 5, 0, 0};
      vecs[3] = '{0, 10, 10, 0, 5, 2,     10, 10, 0, 5};
      vecs[4] = '{0, 10, 10, 5, 0, 2,     10, 10, 5, 0};
      vecs[5] = '{0, 159, 119, 1, 1, 7,   159, 119, 1, 1};
      vecs[6] = '{0, 5, 120, 3, 3, 4,     5, 120, 3, 0};
      vecs[7] = '{0, 150, 0, 255, 2, 6,   150, 0, 10, 2};
      vecs[8] = '{1, 77, 33, 9, 9, 0,     0, 0, 160, 120};

      #1;
      check("reset_outputs", int'({x, y, colour, plot, busy, done}), 0);
      @(posedge CLOCK_50); #2;
      resetn = 1'b1;

      for (int i = 0; i < 9; i++) run_vec(vecs[i], 1'b0, $sformatf("vec%0d", i));

      run_vec(vecs[0], 1'b1, "ignored_start");

      // Abort at the third pixel of a 3x2 fill.
      @(negedge CLOCK_50);
      x_in = 8'd10; y_in = 7'd20; w_in = 8'd3; h_in = 7'd2; colour_in = 3'd5; start = 1'b1;
      @(posedge CLOCK_50); #1;
      start = 1'b0;
      @(posedge CLOCK_50); #1;
      @(posedge CLOCK_50); #1;
      check("abort_pixel3_x", int'(x), 12);
      check("abort_pixel3_plot", int'(plot), 1);
      #2 resetn = 1'b0;
      #1;
      check("abort_async_outputs", int'({x, y, colour, plot, busy, done}), 0);
      @(posedge CLOCK_50); #2;
      resetn = 1'b1;
      pc = 0; dc = 0;
      for (int c = 0; c < 8; c++) begin
         @(posedge CLOCK_50); #1;
         if (plot === 1'b1) pc++;
         if (done === 1'b1 || busy === 1'b1) dc++;
      end
      check("abort_no_plots", pc, 0);
      check("abort_no_done_busy", dc, 0);

      // A start driven right after release is taken on the first edge.
      #2 resetn = 1'b0;
      @(posedge CLOCK_50); #2;
      resetn = 1'b1;
      run_vec(vecs[0], 1'b0, "post_reset");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
